bin_excess3_seq: RTL and testbench
==================================

BIN_EXCESS3_SEQ -- requirements
Module: bin_excess3_seq

Parameters
REQ-001 The block SHALL have parameter W, default 8, giving the binary input width; legal values are W >= 4.
REQ-002 The block SHALL have parameter DIGITS, default 3, giving the number of decimal output digits; legal values are DIGITS >= 1.

Interface
REQ-003 clk  input  1  -- the single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  -- reset, asynchronous and active-high.
REQ-005 start  input  1  -- conversion request; it SHALL be sampled only on edges where busy=0.
REQ-006 mode  input  1  -- output code select (0 = plain BCD 8421, 1 = excess-3); it SHALL be latched together with a.
REQ-007 a  input  W  -- unsigned binary operand; it SHALL be latched on the accepting edge.
REQ-008 y  output  4*DIGITS  -- result; digit k SHALL occupy y[4k+3:4k], with the least-significant digit at k=0.
REQ-009 busy  output  1  -- high while a conversion is in progress.
REQ-010 done  output  1  -- one-cycle completion pulse.
REQ-011 ovf  output  1  -- set when the latched a is >= 10^DIGITS; valid together with y.

Function
REQ-012 The FSM SHALL have the states IDLE, SHIFT, FORMAT and DONE; busy SHALL be 1 in SHIFT and FORMAT, and 0 in IDLE and DONE.
REQ-013 On an edge in IDLE or DONE with start=1, the block SHALL:
- load a into the shift register;
- clear the digit register, the iteration counter and the internal overflow flag;
- latch mode;
- move to SHIFT.
REQ-014 On an edge in IDLE or DONE with start=0, the state SHALL become IDLE.
REQ-015 On each SHIFT edge, the block SHALL:
- add 3 to every digit >= 5;
- shift the {digits, binary} register left by one, with the binary MSB entering digit 0;
- increment the counter.
REQ-016 The bit shifted out of the top digit on each SHIFT edge SHALL be ORed into the internal overflow flag, so that the flag is sticky.
REQ-017 After exactly W SHIFT edges, the state SHALL become FORMAT.
REQ-018 On the FORMAT edge, the block SHALL:
- load y with the digits, each +3 (mod 16) if the latched mode=1, or unchanged if mode=0;
- load ovf from the internal flag;
- move to DONE.
REQ-019 done SHALL be 1 only in the DONE state, i.e. for exactly one cycle per conversion.
REQ-020 Latency: if start is accepted at edge 0, done SHALL be high between edges W+1 and W+2.
REQ-021 y and ovf SHALL hold their values from the FORMAT edge until the next FORMAT edge.
REQ-022 If a >= 10^DIGITS, y SHALL encode (a mod 10^DIGITS) and ovf SHALL be 1; otherwise ovf SHALL be 0.
REQ-023 start=1 while busy=1 SHALL be ignored, with no effect on state, counter, y or ovf.
REQ-024 start=1 while in DONE SHALL be accepted, giving back-to-back conversions: done pulses are W+2 cycles apart.
REQ-025 Changes on a or mode after the accepting edge SHALL NOT affect the result in progress.
REQ-026 The iteration counter SHALL be clog2(W+1) bits wide and SHALL NOT wrap within a conversion.

Reset
REQ-027 While rst=1, the block SHALL immediately force state=IDLE and y=0, with busy, done, ovf, counter and internal registers all 0, regardless of clk.
REQ-028 Reset asserted mid-conversion SHALL abort the conversion; no done pulse SHALL follow.
REQ-029 After rst deasserts, the first edge with start=1 SHALL begin a new conversion.

Verification (W=8, DIGITS=3 unless noted)
REQ-030 a=0, mode=1, start pulse -> done high 9 edges later (edge W+1), y=0x333, ovf=0; mode=0 -> y=0x000.
REQ-031 a=255: with mode=0 -> y=0x255, ovf=0; with mode=1 -> y=0x588.
REQ-032 a=9, mode=1 -> y=0x33C; a=10, mode=1 -> y=0x343; a=99, mode=0 -> y=0x099.
REQ-033 DIGITS=2, a=123, mode=1 -> y=0x56, ovf=1; a=99 -> y=0xCC, ovf=0.
REQ-034 A start pulse 3 cycles after acceptance is ignored (one done only, result of first a); start held high through DONE -> second conversion, done pulses 10 cycles apart.
REQ-035 rst pulsed 4 cycles into a conversion -> all outputs 0 at once, no done; a new start then completes normally with the correct y.

Source files
------------

// File: rtl/bin_excess3_seq.sv
// bin_excess3_seq: sequential binary-to-decimal converter (shift-and-add-3).
// After a start request it takes W shift steps and one format step. The
// result is then presented as plain BCD (8421) or as excess-3, depending on
// the latched mode. An overflow flag reports operands >= 10^DIGITS.
module bin_excess3_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [W-1:0]          a,
    output logic [4*DIGITS-1:0]   y,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int unsigned CW = $clog2(W + 1);
    localparam int unsigned YW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FORMAT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    bin_q, bin_d;
    logic [YW-1:0]   dig_q, dig_d;
    logic [YW-1:0]   dig_adj;
    logic [YW-1:0]   y_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_int_q, ovf_int_d;
    logic            mode_q, mode_d;
    logic            ovf_d;

    // Add-3 correction: a digit >= 5 becomes >= 10 after doubling, so the
    // correction makes the doubling carry into the next digit.
    always_comb begin
        dig_adj = dig_q;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (dig_q[4*k +: 4] >= 4'd5) begin
                dig_adj[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath update for every register.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        dig_d     = dig_q;
        cnt_d     = cnt_q;
        ovf_int_d = ovf_int_q;
        mode_d    = mode_q;
        y_d       = y;
        ovf_d     = ovf;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    bin_d     = a;
                    dig_d     = '0;
                    cnt_d     = '0;
                    ovf_int_d = 1'b0;
                    mode_d    = mode;
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end

            SHIFT: begin
                // The bit leaving the top digit is worth 10^DIGITS. Any such
                // bit means the operand does not fit, and the flag stays set.
                ovf_int_d = ovf_int_q | dig_adj[YW-1];
                dig_d     = {dig_adj[YW-2:0], bin_q[W-1]};
                bin_d     = {bin_q[W-2:0], 1'b0};
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = FORMAT;
                end
            end

            FORMAT: begin
                for (int unsigned k = 0; k < DIGITS; k++) begin
                    if (mode_q) begin
                        y_d[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
                    end else begin
                        y_d[4*k +: 4] = dig_q[4*k +: 4];
                    end
                end
                ovf_d   = ovf_int_q;
                state_d = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            dig_q     <= '0;
            cnt_q     <= '0;
            ovf_int_q <= 1'b0;
            mode_q    <= 1'b0;
            y         <= '0;
            ovf       <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            dig_q     <= dig_d;
            cnt_q     <= cnt_d;
            ovf_int_q <= ovf_int_d;
            mode_q    <= mode_d;
            y         <= y_d;
            ovf       <= ovf_d;
        end
    end

    // Status outputs are decoded directly from the state register.
    always_comb begin
        busy = (state_q == SHIFT) || (state_q == FORMAT);
        done = (state_q == DONE);
    end

endmodule

// File: tb/tb_bin_excess3_seq.sv
// Testbench for bin_excess3_seq. Two instances (DIGITS=3 and DIGITS=2) share
// the same stimulus and are checked against a decimal arithmetic model.
module tb_bin_excess3_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [11:0]  y3;
    logic [7:0]   y2;
    logic         busy, done, ovf3;
    logic         busy2, done2, ovf2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] prev3, prev2, prev_ovf3, prev_ovf2;

    bin_excess3_seq #(.W(W), .DIGITS(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a),
        .y(y3), .busy(busy), .done(done), .ovf(ovf3)
    );

    bin_excess3_seq #(.W(W), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a),
        .y(y2), .busy(busy2), .done(done2), .ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: decimal digits of (val mod 10^nd), each optionally +3 mod 16.
    function automatic logic [31:0] ref_y(input int unsigned val, input bit m, input int unsigned nd);
        int unsigned v;
        int unsigned d;
        logic [31:0] r;
        v = val;
        r = '0;
        for (int unsigned k = 0; k < nd; k++) begin
            d = v % 10;
            v = v / 10;
            if (m) d = (d + 3) % 16;
            r = r | (32'(d) << (4 * k));
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_ovf(input int unsigned val, input int unsigned nd);
        return (val >= 10 ** nd) ? 32'd1 : 32'd0;
    endfunction

    // From a negedge, count rising edges until done is seen (bounded).
    task automatic wait_done(input int from, output int edges);
        edges = from;
        while (!done && edges < 4 * W) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string tag, input int unsigned av, input bit m);
        logic [31:0] e3, e2;
        e3 = ref_y(av, m, 3);
        e2 = ref_y(av, m, 2);
        check({tag, "_y3"}, 32'(y3), e3);
        check({tag, "_ovf3"}, 32'(ovf3), ref_ovf(av, 3));
        check({tag, "_y2"}, 32'(y2), e2);
        check({tag, "_ovf2"}, 32'(ovf2), ref_ovf(av, 2));
        check({tag, "_done2"}, 32'(done2), 32'd1);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        prev3     = e3;
        prev2     = e2;
        prev_ovf3 = ref_ovf(av, 3);
        prev_ovf2 = ref_ovf(av, 2);
    endtask

    task automatic convert(input string tag, input logic [W-1:0] av, input logic m);
        int edges;
        @(negedge clk);
        start = 1'b1; a = av; mode = m;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom_range(0, 255));
        mode  = 1'($urandom_range(0, 1));
        check({tag, "_busy_on"}, 32'(busy), 32'd1);
        check({tag, "_y_hold"}, 32'(y3), prev3);
        wait_done(0, edges);
        check({tag, "_latency"}, 32'(edges), 32'(W + 1));
        check_result(tag, av, m);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_y_keep"}, 32'(y3), prev3);
        check({tag, "_ovf_keep"}, 32'(ovf3), prev_ovf3);
    endtask

    initial begin
        int e1, e2, cnt;
        logic [W-1:0] a1, a2;
        logic m1, m2;

        rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0;
        prev3 = '0; prev2 = '0; prev_ovf3 = '0; prev_ovf2 = '0;
        #12;
        check("rst_y3", 32'(y3), 32'd0);
        check("rst_y2", 32'(y2), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf3), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases, including decimal boundaries for both widths.
        convert("a0_m1", 8'd0, 1'b1);
        convert("a0_m0", 8'd0, 1'b0);
        convert("a255_m0", 8'd255, 1'b0);
        convert("a255_m1", 8'd255, 1'b1);
        convert("a9_m1", 8'd9, 1'b1);
        convert("a10_m1", 8'd10, 1'b1);
        convert("a99_m0", 8'd99, 1'b0);
        convert("a99_m1", 8'd99, 1'b1);
        convert("a100_m0", 8'd100, 1'b0);
        convert("a123_m1", 8'd123, 1'b1);

        // Random operands and modes.
        for (int i = 0; i < 40; i++) begin
            convert("rand", W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        // A start pulse during busy is ignored.
        a1 = 8'd201; m1 = 1'b0;
        @(negedge clk);
        start = 1'b1; a = a1; mode = m1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 8'd7; mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b1; a = 8'd42;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(3, e1);
        check("ign_latency", 32'(e1), 32'(W + 1));
        check_result("ign", a1, m1);
        cnt = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) cnt++;
        end
        check("ign_extra_done", 32'(cnt), 32'd0);

        // start held high through DONE: back-to-back conversions.
        a1 = 8'd58; m1 = 1'b1; a2 = 8'd187; m2 = 1'b0;
        @(negedge clk);
        start = 1'b1; a = a1; mode = m1;
        @(posedge clk);
        @(negedge clk);
        a = a2; mode = m2;
        wait_done(0, e1);
        check("b2b_latency1", 32'(e1), 32'(W + 1));
        check_result("b2b1", a1, m1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 8'd3; mode = 1'b1;
        check("b2b_busy_again", 32'(busy), 32'd1);
        wait_done(0, e2);
        check("b2b_gap", 32'(e2 + 1), 32'(W + 2));
        check_result("b2b2", a2, m2);
        @(posedge clk);
        @(negedge clk);

        // Reset in the middle of a conversion.
        @(negedge clk);
        start = 1'b1; a = 8'd77; mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("mid_rst_y3", 32'(y3), 32'd0);
        check("mid_rst_y2", 32'(y2), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_ovf", 32'(ovf3), 32'd0);
        prev3 = '0; prev2 = '0; prev_ovf3 = '0; prev_ovf2 = '0;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("mid_rst_no_done", 32'(cnt), 32'd0);
        convert("after_rst", 8'd164, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
